// File: rtl/reg_file_sb.sv
// Parametrised register file with per-register pending scoreboard and a sequential clear sweep.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_pend_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_pend_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              clr_busy_q, clr_busy_d;
  logic              wr_drop_q, wr_drop_d;
  logic              wr_ok, mark_ok;

  always_comb begin
    wr_ok   = wr_en   && !clr_busy_q && (wr_addr   != '0);
    mark_ok = mark_en && !clr_busy_q && (mark_addr != '0);
  end

  // Counter starts at 1 because register 0 is never written and needs no clearing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = ADDR_W'(1);
        end
      end
      SWEEP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    clr_busy_d = (state_d == SWEEP);
    wr_drop_d  = clr_busy_q && ((wr_en && (wr_addr != '0)) || (mark_en && (mark_addr != '0)));
  end

  // Mark is applied after the write so a same-address mark leaves the register pending.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_ok) begin
      mem_d[wr_addr]  = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (mark_ok) begin
      pend_d[mark_addr] = 1'b1;
    end
    if (state_q == SWEEP) begin
      mem_d[cnt_q]  = '0;
      pend_d[cnt_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      clr_busy_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      clr_busy_q <= clr_busy_d;
      wr_drop_q  <= wr_drop_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  logic [DATA_W-1:0] stored_a, stored_b;
  logic              spend_a, spend_b;

  always_comb begin
    stored_a = (rd_addr_a == '0) ? '0 : mem_q[rd_addr_a];
    stored_b = (rd_addr_b == '0) ? '0 : mem_q[rd_addr_b];
    spend_a  = (rd_addr_a != '0) && pend_q[rd_addr_a];
    spend_b  = (rd_addr_b != '0) && pend_q[rd_addr_b];
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_a, byp_b;

  always_comb begin
    byp_a     = wr_ok && (wr_addr == rd_addr_a);
    byp_b     = wr_ok && (wr_addr == rd_addr_b);
    rd_data_a = byp_a ? wr_data : stored_a;
    rd_data_b = byp_b ? wr_data : stored_b;
    rd_pend_a = byp_a ? (mark_ok && (mark_addr == rd_addr_a)) : spend_a;
    rd_pend_b = byp_b ? (mark_ok && (mark_addr == rd_addr_b)) : spend_b;
  end
`else
  always_comb begin
    rd_data_a = stored_a;
    rd_data_b = stored_b;
    rd_pend_a = spend_a;
    rd_pend_b = spend_b;
  end
`endif

  assign clr_busy = clr_busy_q;
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed test of reg_file_sb: default 8x16 instance plus a 32x32 instance for the wide sweep.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic        d_wr_en, d_mark_en, d_clr_req;
  logic [2:0]  d_wr_addr, d_mark_addr, d_ra, d_rb;
  logic [15:0] d_wr_data, d_da, d_db;
  logic        d_pa, d_pb, d_busy, d_drop;

  // wide instance
  logic        w_wr_en, w_mark_en, w_clr_req;
  logic [4:0]  w_wr_addr, w_mark_addr, w_ra, w_rb;
  logic [31:0] w_wr_data, w_da, w_db;
  logic        w_pa, w_pb, w_busy, w_drop;

  int checks = 0;
  int failures = 0;

  reg_file_sb u_dut (
    .clk(clk), .rst(rst),
    .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
    .mark_en(d_mark_en), .mark_addr(d_mark_addr),
    .rd_addr_a(d_ra), .rd_data_a(d_da), .rd_pend_a(d_pa),
    .rd_addr_b(d_rb), .rd_data_b(d_db), .rd_pend_b(d_pb),
    .clr_req(d_clr_req), .clr_busy(d_busy), .wr_drop(d_drop)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5)) u_wide (
    .clk(clk), .rst(rst),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .mark_en(w_mark_en), .mark_addr(w_mark_addr),
    .rd_addr_a(w_ra), .rd_data_a(w_da), .rd_pend_a(w_pa),
    .rd_addr_b(w_rb), .rd_data_b(w_db), .rd_pend_b(w_pb),
    .clr_req(w_clr_req), .clr_busy(w_busy), .wr_drop(w_drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_wr_en = 0; d_mark_en = 0; d_clr_req = 0;
    w_wr_en = 0; w_mark_en = 0; w_clr_req = 0;
  endtask

  task automatic d_write(input logic [2:0] a, input logic [15:0] v);
    d_wr_en = 1; d_wr_addr = a; d_wr_data = v;
    step();
    d_wr_en = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    d_wr_addr = 0; d_wr_data = 0; d_mark_addr = 0; d_ra = 0; d_rb = 0;
    w_wr_addr = 0; w_wr_data = 0; w_mark_addr = 0; w_ra = 0; w_rb = 0;
    step(); step();
    rst = 0;
    #1;
    checks++;
    if (d_busy !== 1'b0 || d_drop !== 1'b0) begin
      failures++;
      $display("FAIL reset_status busy=%b drop=%b expected 0 0", d_busy, d_drop);
    end
    for (int i = 0; i < 8; i++) begin
      d_ra = 3'(i); d_rb = 3'(7 - i);
      #1;
      checks++;
      if (d_da !== 16'h0 || d_db !== 16'h0 || d_pa !== 1'b0 || d_pb !== 1'b0) begin
        failures++;
        $display("FAIL reset_read i=%0d a=%h/%b b=%h/%b expected 0000/0", i, d_da, d_pa, d_db, d_pb);
      end
    end
    step();
    d_write(3'd0, 16'hBEEF);
    d_ra = 0;
    #1;
    checks++;
    if (d_da !== 16'h0 || d_pa !== 1'b0) begin
      failures++;
      $display("FAIL r0_write data=%h pend=%b expected 0000 0", d_da, d_pa);
    end
  endtask

  task automatic test_write_latency();
    d_ra = 3'd5;
    d_wr_en = 1; d_wr_addr = 3'd5; d_wr_data = 16'h1234;
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (d_da !== 16'h1234) begin
      failures++;
      $display("FAIL write_same_cycle data=%h expected 1234", d_da);
    end
`else
    if (d_da !== 16'h0000) begin
      failures++;
      $display("FAIL write_same_cycle data=%h expected 0000", d_da);
    end
`endif
    step();
    d_wr_en = 0;
    #1;
    checks++;
    if (d_da !== 16'h1234) begin
      failures++;
      $display("FAIL write_next_cycle data=%h expected 1234", d_da);
    end
  endtask

  task automatic test_mark();
    d_rb = 3'd3;
    d_mark_en = 1; d_mark_addr = 3'd3;
    step();
    d_mark_en = 0;
    #1;
    checks++;
    if (d_pb !== 1'b1) begin
      failures++;
      $display("FAIL mark_pend pend=%b expected 1", d_pb);
    end
    d_write(3'd3, 16'h00AA);
    #1;
    checks++;
    if (d_pb !== 1'b0 || d_db !== 16'h00AA) begin
      failures++;
      $display("FAIL write_clears_pend data=%h pend=%b expected 00aa 0", d_db, d_pb);
    end
    d_mark_en = 1; d_mark_addr = 3'd3;
    d_write(3'd3, 16'h0055);
    d_mark_en = 0;
    #1;
    checks++;
    if (d_pb !== 1'b1 || d_db !== 16'h0055) begin
      failures++;
      $display("FAIL mark_and_write data=%h pend=%b expected 0055 1", d_db, d_pb);
    end
    d_ra = 3'd5;
    #1;
    checks++;
    if (d_pa !== 1'b0 || d_da !== 16'h1234) begin
      failures++;
      $display("FAIL mark_isolation r5=%h pend=%b expected 1234 0", d_da, d_pa);
    end
  endtask

  task automatic test_back_to_back();
    d_write(3'd1, 16'h1111);
    d_write(3'd2, 16'h2222);
    d_write(3'd6, 16'h6666);
    d_ra = 3'd2; d_rb = 3'd6;
    #1;
    checks++;
    if (d_da !== 16'h2222 || d_db !== 16'h6666) begin
      failures++;
      $display("FAIL back_to_back a=%h b=%h expected 2222 6666", d_da, d_db);
    end
    d_ra = 3'd1;
    #1;
    checks++;
    if (d_da !== 16'h1111) begin
      failures++;
      $display("FAIL back_to_back_r1 a=%h expected 1111", d_da);
    end
  endtask

  task automatic test_sweep();
    int busy_n;
    int drop_n;
    for (int i = 1; i < 8; i++) d_write(3'(i), 16'hFFFF);
    d_mark_en = 1; d_mark_addr = 3'd4;
    step();
    d_mark_en = 0;
    d_clr_req = 1;
    d_ra = 3'd1;
    step();
    d_clr_req = 0;
    #1;
    checks++;
    if (d_busy !== 1'b1 || d_da !== 16'hFFFF) begin
      failures++;
      $display("FAIL sweep_start busy=%b r1=%h expected 1 ffff", d_busy, d_da);
    end
    busy_n = 0;
    drop_n = 0;
    while (d_busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      if (busy_n == 1) begin d_wr_en = 1; d_wr_addr = 3'd2; d_wr_data = 16'h0001; end
      if (busy_n == 3) begin d_mark_en = 1; d_mark_addr = 3'd1; end
      if (busy_n == 4) d_clr_req = 1;
      step();
      d_wr_en = 0; d_mark_en = 0; d_clr_req = 0;
      #1;
      if (d_drop === 1'b1) drop_n++;
      if (busy_n == 1) begin
        checks++;
        if (d_da !== 16'h0000 || d_drop !== 1'b1) begin
          failures++;
          $display("FAIL sweep_first_cycle r1=%h drop=%b expected 0000 1", d_da, d_drop);
        end
      end
    end
    checks++;
    if (busy_n != 7) begin
      failures++;
      $display("FAIL sweep_length busy_cycles=%0d expected 7", busy_n);
    end
    checks++;
    if (drop_n != 2) begin
      failures++;
      $display("FAIL sweep_drops pulses=%0d expected 2", drop_n);
    end
    step();
    checks++;
    if (d_busy !== 1'b0 || d_drop !== 1'b0) begin
      failures++;
      $display("FAIL sweep_no_restart busy=%b drop=%b expected 0 0", d_busy, d_drop);
    end
    for (int i = 0; i < 8; i++) begin
      d_ra = 3'(i);
      #1;
      checks++;
      if (d_da !== 16'h0 || d_pa !== 1'b0) begin
        failures++;
        $display("FAIL sweep_cleared r%0d data=%h pend=%b expected 0000 0", i, d_da, d_pa);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 1; i < 8; i++) d_write(3'(i), 16'hA5A5);
    d_clr_req = 1;
    step();
    d_clr_req = 0;
    step(); step(); step();
    rst = 1;
    #1;
    checks++;
    if (d_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort busy=%b expected 0", d_busy);
    end
    for (int i = 4; i < 8; i++) begin
      d_ra = 3'(i);
      #1;
      checks++;
      if (d_da !== 16'h0) begin
        failures++;
        $display("FAIL reset_abort_clear r%0d=%h expected 0000", i, d_da);
      end
    end
    step();
    rst = 0;
    d_ra = 3'd4;
    d_write(3'd4, 16'h4444);
    #1;
    checks++;
    if (d_da !== 16'h4444 || d_busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_write r4=%h busy=%b expected 4444 0", d_da, d_busy);
    end
  endtask

  task automatic test_wide();
    int busy_n;
    w_ra = 5'd31;
    w_wr_en = 1; w_wr_addr = 5'd31; w_wr_data = 32'hDEADBEEF;
    step();
    w_wr_en = 0;
    #1;
    checks++;
    if (w_da !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wide_r31 data=%h expected deadbeef", w_da);
    end
    w_wr_en = 1; w_wr_addr = 5'd1; w_wr_data = 32'h01010101;
    step();
    w_wr_en = 0;
    w_clr_req = 1;
    step();
    w_clr_req = 0;
    busy_n = 0;
    while (w_busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      step();
    end
    checks++;
    if (busy_n != 31) begin
      failures++;
      $display("FAIL wide_sweep_length busy_cycles=%0d expected 31", busy_n);
    end
    #1;
    checks++;
    if (w_da !== 32'h0) begin
      failures++;
      $display("FAIL wide_r31_cleared data=%h expected 00000000", w_da);
    end
    w_rb = 5'd1;
    w_wr_en = 1; w_wr_addr = 5'd1; w_wr_data = 32'h12345678;
    step();
    w_wr_en = 0;
    step(); step();
    checks++;
    if (w_db !== 32'h12345678 || w_busy !== 1'b0) begin
      failures++;
      $display("FAIL wide_no_wrap r1=%h busy=%b expected 12345678 0", w_db, w_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_mark();
    test_back_to_back();
    test_sweep();
    test_reset_mid_sweep();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised general-purpose register file for the 16-bit Harvard core, generalising the 8×16 register file to DATA_W × 2^ADDR_W. It provides two combinational read ports, one write port, a per-register pending (scoreboard) bit for in-flight writebacks, and a sequential clear sweep. It sits between decode (read, mark) and writeback (write), and lets the hazard unit stall on pending source registers.

## Interface
Parameters:
- DATA_W, default 16: register width in bits.
- ADDR_W, default 3: address width; DEPTH = 2^ADDR_W registers (default 8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- mark_en  in  1  decode issues an instruction; mark destination pending.
- mark_addr  in  ADDR_W  register to mark pending.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data (combinational).
- rd_pend_a  out  1  pending bit of rd_addr_a (combinational).
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data (combinational).
- rd_pend_b  out  1  pending bit of rd_addr_b (combinational).
- clr_req  in  1  request to zero all registers and pending bits.
- clr_busy  out  1  clear sweep in progress (registered).
- wr_drop  out  1  one-cycle pulse: a write or mark was discarded during a sweep (registered).

## Operation
- Register 0 is hardwired to zero: reads return 0, pend reads 0, writes and marks to address 0 are ignored.
- Write: when wr_en and clr_busy=0 and wr_addr≠0, reg[wr_addr] ← wr_data and pend[wr_addr] ← 0 on the clock edge.
- Mark: when mark_en and clr_busy=0 and mark_addr≠0, pend[mark_addr] ← 1.
- Mark and write to the same address in the same cycle: data is written and pend ends at 1, because the mark is a newer producer.
- Reads are pure combinational lookups of the array and pend vector (bypass: see Configuration).
- Sweep FSM, states IDLE and SWEEP:
  - IDLE → SWEEP on clr_req. The counter loads 1 and clr_busy rises on the following edge.
  - In SWEEP, each cycle clears reg[cnt] and pend[cnt], then cnt increments.
  - SWEEP → IDLE on the edge that clears reg[DEPTH-1]. clr_busy is 1 for exactly DEPTH-1 cycles.
  - clr_req while in SWEEP is ignored (no restart).
  - Counter is ADDR_W bits and must not wrap past DEPTH-1.
- While clr_busy=1, wr_en and mark_en are discarded. wr_drop is 1 on the next cycle if either was asserted with a nonzero address.
- Reads during a sweep return current array contents, which are partially cleared.

## Timing
- Reset values: all registers 0, all pend 0, FSM IDLE, counter 0, clr_busy 0, wr_drop 0. rd_data_*/rd_pend_* are then 0 for every address.
- Reset asserted mid-sweep aborts the sweep immediately. All state returns to reset values, and the sweep does not resume after reset release.
- Write latency: data is visible on the read ports in the cycle after the wr_en edge (same cycle with bypass).
- Mark latency: pend is visible the cycle after the mark_en edge.
- A clr_req in cycle N blocks writes from cycle N+1 through N+DEPTH-1. A write in cycle N itself is accepted, and the sweep then clears it.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wr_en, clr_busy=0, wr_addr≠0 and wr_addr==rd_addr_x, rd_data_x = wr_data in the same cycle.
  - rd_pend_x reads 0 in that cycle unless mark_en targets the same address in the same cycle.
- Not defined: reads return stored array values and stored pend bits only. The write becomes visible one cycle later.

## Test plan
- Reset, then read all addresses → every rd_data = 0x0000, rd_pend = 0. Write 0xBEEF to r0 → r0 still reads 0x0000.
- Write r5=0x1234 in cycle N, read r5 on port A → 0x1234 from cycle N+1. With REGFILE_BYPASS_EN, 0x1234 in cycle N.
- Mark r3, read r3 on port B → rd_pend_b=1 next cycle. Write r3=0x00AA → pend 0 next cycle. Simultaneous mark+write r3=0x0055 → data 0x0055, pend 1.
- Fill r1..r7 with 0xFFFF, pulse clr_req → clr_busy high for 7 cycles. r1 reads 0 after the first sweep cycle, all read 0 at the end. A write r2=0x0001 during the sweep is lost and wr_drop pulses once.
- Assert rst after 3 sweep cycles → clr_busy=0 immediately, all registers 0. After release, writes are accepted on the first edge.
- Parameter run DATA_W=32, ADDR_W=5 → 31-cycle sweep. Write r31=0xDEADBEEF reads back correctly, and the counter does not wrap.
